// File: rtl/mac_seq_if.sv
// rtl/mac_seq_if.sv - start/operand/result handshake bundle for mac_seq
interface mac_seq_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
);
  logic               start;
  logic [len_bw-1:0]  start_len;
  logic [psum_bw-1:0] start_bias;
  logic               in_valid;
  logic               in_ready;
  logic [bw-1:0]      in_a;
  logic [bw-1:0]      in_b;
  logic               out_valid;
  logic               out_ready;
  logic [psum_bw-1:0] out_psum;
  logic               busy;
  logic [len_bw-1:0]  remaining;

  modport master (
    output start, start_len, start_bias, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_psum, busy, remaining
  );

  modport slave (
    input  start, start_len, start_bias, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_psum, busy, remaining
  );
endinterface

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - sequential dot-product engine: unsigned activations times signed weights plus bias
module mac_seq #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input  logic     clk,
  input  logic     reset,
  mac_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [psum_bw-1:0] acc_q, acc_d;
  logic [len_bw-1:0]  rem_q, rem_d;

  logic [psum_bw-1:0] a_ext, b_ext, product;
  logic               xfer;

  // Both operands widened to psum_bw first; the truncated product is exact modulo 2^psum_bw.
  always_comb begin
    a_ext   = {{(psum_bw-bw){1'b0}}, bus.in_a};
    b_ext   = {{(psum_bw-bw){bus.in_b[bw-1]}}, bus.in_b};
    product = a_ext * b_ext;
    xfer    = (state_q == ACC) && bus.in_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.start_bias;
          rem_d   = bus.start_len;
          state_d = (bus.start_len != '0) ? ACC : HOLD;
        end
      end
      ACC: begin
        if (xfer) begin
          acc_d = acc_q + product;
          rem_d = rem_q - 1'b1;
          if (rem_q == len_bw'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ACC);
    bus.out_valid = (state_q == HOLD);
    bus.busy      = (state_q != IDLE);
    bus.out_psum  = acc_q;
    bus.remaining = rem_q;
  end

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - randomized self-checking bench for mac_seq against an arithmetic dot-product model
module tb_mac_seq;
  localparam int BW = 4;
  localparam int PW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  int   pa [64];
  int   pb [64];
  logic [15:0] last_psum;

  mac_seq_if #(.bw(BW), .psum_bw(PW), .len_bw(LW)) bus ();

  mac_seq #(.bw(BW), .psum_bw(PW), .len_bw(LW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_prod(input int a, input int b);
    int bs;
    bs = (b >= 8) ? b - 16 : b;
    return 16'(a * bs);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: start, len transfers with gaps, hold for `hold` cycles, then release.
  task automatic run_dot(input logic [15:0] bias, input int len, input int gap,
                         input bit gap_rand, input int hold, input bit noise);
    logic [15:0] exp;
    int g;
    exp = bias;
    bus.start      = 1'b1;
    bus.start_len  = len[7:0];
    bus.start_bias = bias;
    step();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("rem_loaded", bus.remaining, len);
    check("in_ready_after_start", bus.in_ready, (len != 0));
    check("out_valid_after_start", bus.out_valid, (len == 0));
    for (int i = 0; i < len; i++) begin
      g = gap_rand ? $urandom_range(0, gap) : gap;
      repeat (g) begin
        bus.start      = noise & $urandom_range(0, 1);
        bus.start_len  = 8'($urandom_range(0, 255));
        bus.start_bias = 16'($urandom);
        step();
        bus.start = 1'b0;
        check("gap_psum", bus.out_psum, exp);
        check("gap_rem", bus.remaining, len - i);
        check("gap_in_ready", bus.in_ready, 1);
      end
      bus.in_valid = 1'b1;
      bus.in_a     = pa[i][3:0];
      bus.in_b     = pb[i][3:0];
      step();
      bus.in_valid = 1'b0;
      exp = exp + model_prod(pa[i], pb[i]);
      check("acc", bus.out_psum, exp);
      check("rem", bus.remaining, len - i - 1);
      check("valid_after_xfer", bus.out_valid, (i == len - 1));
    end
    bus.out_ready = 1'b0;
    repeat (hold) begin
      bus.start      = noise & $urandom_range(0, 1);
      bus.start_len  = 8'($urandom_range(0, 255));
      bus.start_bias = 16'($urandom);
      bus.in_valid   = noise & $urandom_range(0, 1);
      step();
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_psum", bus.out_psum, exp);
    end
    check("result", bus.out_psum, exp);
    check("result_valid", bus.out_valid, 1);
    last_psum      = bus.out_psum;
    bus.out_ready  = 1'b1;
    bus.start      = noise;
    bus.start_len  = 8'd5;
    bus.start_bias = 16'hDEAD;
    step();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("release_valid", bus.out_valid, 0);
    check("release_busy", bus.busy, 0);
    check("release_in_ready", bus.in_ready, 0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.start_len  = '0;
    bus.start_bias = '0;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.out_ready  = 1'b0;
    step();
    step();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_psum", bus.out_psum, 0);
    check("rst_rem", bus.remaining, 0);
    reset = 1'b0;
    step();

    pa[0] = 3;  pb[0] = 2;
    pa[1] = 15; pb[1] = 15;
    pa[2] = 7;  pb[2] = 8;
    run_dot(16'h0000, 3, 0, 0, 0, 0);
    check("basic_const", last_psum, 16'hFFBF);

    run_dot(16'h1234, 0, 0, 0, 1, 0);
    check("zero_len_const", last_psum, 16'h1234);

    pa[0] = 15; pb[0] = 8;
    pa[1] = 9;  pb[1] = 5;
    run_dot(16'h0100, 2, 3, 0, 5, 1);

    pa[0] = 15; pb[0] = 7;
    run_dot(16'h7FFF, 1, 0, 0, 0, 0);
    check("wrap_pos_const", last_psum, 16'h8068);
    pa[0] = 1;  pb[0] = 15;
    run_dot(16'h0000, 1, 0, 0, 0, 0);
    check("wrap_neg_const", last_psum, 16'hFFFF);

    pa[0] = 0;  pb[0] = 8;
    pa[1] = 4;  pb[1] = 3;
    run_dot(16'h0010, 2, 0, 0, 1, 1);
    run_dot(16'h0020, 1, 0, 0, 0, 0);

    bus.start      = 1'b1;
    bus.start_len  = 8'd4;
    bus.start_bias = 16'h0055;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd5;
      bus.in_b     = 4'd3;
      step();
    end
    bus.in_valid = 1'b0;
    check("pre_reset_rem", bus.remaining, 2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_in_ready", bus.in_ready, 0);
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_psum", bus.out_psum, 0);
    check("async_rst_rem", bus.remaining, 0);
    step();
    reset = 1'b0;
    step();
    step();
    check("post_rst_in_ready", bus.in_ready, 0);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_busy", bus.busy, 0);

    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        pa[i] = $urandom_range(0, 15);
        pb[i] = $urandom_range(0, 15);
      end
      run_dot(16'($urandom), len, 3, 1, $urandom_range(0, 4), $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 SHALL have parameter bw, default 4: activation and weight width.
REQ-002 SHALL have parameter psum_bw, default 16: accumulator and result width.
REQ-003 SHALL have parameter len_bw, default 8: vector-length field width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a dot product; honoured only in IDLE.
REQ-007 SHALL have port start_len  input  len_bw  number of (a,b) pairs in the dot product; sampled with start.
REQ-008 SHALL have port start_bias  input  psum_bw  initial accumulator value (two's complement); sampled with start.
REQ-009 SHALL have port in_valid  input  1  an operand pair is presented.
REQ-010 SHALL have port in_ready  output  1  the block accepts a pair this cycle.
REQ-011 SHALL have port in_a  input  bw  unsigned activation.
REQ-012 SHALL have port in_b  input  bw  two's-complement signed weight.
REQ-013 SHALL have port out_valid  output  1  out_psum holds a finished result.
REQ-014 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-015 SHALL have port out_psum  output  psum_bw  the accumulator value.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port remaining  output  len_bw  pairs still to be accepted.

Function
REQ-018 SHALL implement three states: IDLE, ACC and HOLD.
REQ-019 IDLE: start=1 SHALL load acc<=start_bias and remaining<=start_len; next state SHALL be ACC if start_len!=0, else HOLD.
REQ-020 in_ready SHALL equal (state==ACC) and SHALL be independent of in_valid.
REQ-021 Pair transfer SHALL occur on an edge where in_valid&in_ready=1, and SHALL update acc<=acc+product and remaining<=remaining-1.
REQ-022 product SHALL equal zero-extended in_a times sign-extended in_b, sign-extended to psum_bw; the sum SHALL wrap modulo 2^psum_bw with no saturation or overflow flag.
REQ-023 A transfer with remaining==1 SHALL move the state to HOLD; in_valid=0 in ACC SHALL leave acc and remaining unchanged.
REQ-024 out_valid SHALL equal (state==HOLD); out_psum SHALL always reflect acc and SHALL stay stable while in HOLD.
REQ-025 HOLD with out_ready=1 SHALL go to IDLE on that edge; out_ready=0 SHALL hold HOLD indefinitely.
REQ-026 start SHALL be ignored in ACC and HOLD, including in the HOLD->IDLE handoff cycle; no queuing.
REQ-027 Latency: a start at edge 0 followed by N back-to-back transfers SHALL raise out_valid after edge N (N>=1), or after edge 0 for N=0.
REQ-028 An activation value of 0 or a weight of 4'h8 (-8) SHALL need no special casing; for example, 15*(-8) SHALL add 16'hFF88.
REQ-029 The accumulate SHALL be done in one cycle; an implementation MAY instantiate the team's mac block with c=acc.

Reset
REQ-030 reset=1 SHALL, asynchronously, force state=IDLE, acc=0, remaining=0, in_ready=0, out_valid=0, busy=0 and out_psum=0.
REQ-031 Reset asserted during ACC or HOLD SHALL abandon the operation, with no result emitted after release.
REQ-032 After reset deasserts, the first start SHALL be honoured on the first rising edge at which it is sampled.

Verification
REQ-033 Reset: assert reset mid-ACC (remaining=2) -> immediately all outputs 0, busy=0; after release, in_ready=0 until a new start.
REQ-034 Basic: bias=0, len=3, pairs (3,4'h2),(15,4'hF),(7,4'h8) back-to-back -> out_valid after the 3rd transfer, out_psum=16'hFFBF (6-15-56=-65).
REQ-035 Zero length: start with len=0, bias=16'h1234 -> out_valid next cycle, out_psum=16'h1234, in_ready never high.
REQ-036 Backpressure: len=2 with in_valid gaps of 3 cycles, and out_ready low for 5 cycles in HOLD while start pulses -> acc unchanged in the gaps, out_psum stable, start ignored, one result only.
REQ-037 Wrap: bias=16'h7FFF, len=1, pair (15,4'h7) -> out_psum=16'h8068; bias=16'h0000, pair (1,4'hF) -> 16'hFFFF.
REQ-038 Back-to-back: out_ready=1 with start asserted in the same HOLD cycle -> start ignored; IDLE next; a start one cycle later is accepted.
